// File: rtl/fir_sample_serializer_pkg.sv
// fir_sample_serializer_pkg: shared state encoding and byte/sample width constants
package fir_sample_serializer_pkg;
  localparam int BYTE_W = 8;
  localparam int SAMPLE_W = 16;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;
endpackage

// File: rtl/fir_sample_serializer_if.sv
// fir_sample_serializer_if: sample-in / byte-out handshake bundle
//   in_valid/in_ready/in_data : signed FIR sample offered to the serializer
//   out_valid/out_ready/out_byte : byte stream to the UART TX, MSB first
//   busy : a sample is being sent
interface fir_sample_serializer_if
  import fir_sample_serializer_pkg::*;
#(parameter int WIDTH = SAMPLE_W);
  logic in_valid, in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic out_valid, out_ready;
  logic [BYTE_W-1:0] out_byte;
  logic busy;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_byte, busy);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_byte, busy);
endinterface

// File: rtl/fir_sample_serializer_byte_shift_reg.sv
// fir_sample_serializer_byte_shift_reg: WIDTH-bit register with load and shift-left-by-a-byte
//   clk_i, rst_i (sync, active-high), load_i (priority over shift_i), shift_i, d_i, q_o
module fir_sample_serializer_byte_shift_reg
  import fir_sample_serializer_pkg::*;
#(parameter int WIDTH = SAMPLE_W) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  always_ff @(posedge clk_i)
    if (rst_i) q_o <= '0;
    else if (load_i) q_o <= d_i;
    else if (shift_i) q_o <= q_o << BYTE_W;
endmodule

// File: rtl/fir_sample_serializer.sv
// fir_sample_serializer: unloads signed FIR samples as MSB-first bytes to the UART TX
//   clk_i, rst_i (sync, active-high); bus: slave side of fir_sample_serializer_if
module fir_sample_serializer
  import fir_sample_serializer_pkg::*;
#(parameter int width = SAMPLE_W) (
  input logic clk_i,
  input logic rst_i,
  fir_sample_serializer_if.slave bus
);
  localparam int NBYTES = width / BYTE_W;
  localparam int CW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [width-1:0] shreg;
  logic last, byte_acc, in_acc, shift;
  // a new sample may enter on the same edge the last byte leaves, giving gapless streaming
  always_comb begin
    last = cnt_q == '0;
    bus.busy = state_q == SEND;
    bus.out_valid = bus.busy;
    bus.out_byte = shreg[width-1 -: BYTE_W];
    bus.in_ready = !bus.busy || (last && bus.out_ready);
    byte_acc = bus.out_valid && bus.out_ready;
    in_acc = bus.in_valid && bus.in_ready;
    shift = byte_acc && !last;
    state_d = in_acc ? SEND : (byte_acc && last) ? IDLE : state_q;
    cnt_d = in_acc ? CW'(NBYTES - 1) : shift ? cnt_q - CW'(1) : cnt_q;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  fir_sample_serializer_byte_shift_reg #(.WIDTH(width)) u_shreg (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .load_i(in_acc),
    .shift_i(shift),
    .d_i(bus.in_data),
    .q_o(shreg)
  );
endmodule

// File: tb/tb_fir_sample_serializer.sv
// tb_fir_sample_serializer: 16- and 24-bit serializers driven in parallel against byte-queue models
module tb_fir_sample_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  byte unsigned q16[$];
  byte unsigned q24[$];
  always #5 clk = ~clk;
  fir_sample_serializer_if #(.WIDTH(16)) b16();
  fir_sample_serializer_if #(.WIDTH(24)) b24();
  fir_sample_serializer #(.width(16)) dut16 (.clk_i(clk), .rst_i(rst), .bus(b16.slave));
  fir_sample_serializer #(.width(24)) dut24 (.clk_i(clk), .rst_i(rst), .bus(b24.slave));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic exp_ready(input int n, input logic r);
    return n == 0 || (n == 1 && r);
  endfunction
  // one clock: drive inputs at negedge, check outputs against the models, then advance the models at posedge
  task automatic cyc(input logic v, input logic [23:0] d, input logic r, input logic rs);
    logic ir16, ir24;
    @(negedge clk);
    rst = rs;
    b16.in_valid = v;
    b24.in_valid = v;
    b16.in_data = d[15:0];
    b24.in_data = d;
    b16.out_ready = r;
    b24.out_ready = r;
    #1;
    ir16 = exp_ready(q16.size(), r);
    ir24 = exp_ready(q24.size(), r);
    check("busy16", 32'(b16.busy), 32'(q16.size() != 0));
    check("valid16", 32'(b16.out_valid), 32'(q16.size() != 0));
    check("ready16", 32'(b16.in_ready), 32'(ir16));
    if (q16.size() != 0) check("byte16", 32'(b16.out_byte), 32'(q16[0]));
    check("busy24", 32'(b24.busy), 32'(q24.size() != 0));
    check("valid24", 32'(b24.out_valid), 32'(q24.size() != 0));
    check("ready24", 32'(b24.in_ready), 32'(ir24));
    if (q24.size() != 0) check("byte24", 32'(b24.out_byte), 32'(q24[0]));
    @(posedge clk);
    if (rs) begin
      q16.delete();
      q24.delete();
    end else begin
      if (q16.size() != 0 && r) void'(q16.pop_front());
      if (q24.size() != 0 && r) void'(q24.pop_front());
      if (v && ir16) begin
        q16.push_back(d[15:8]);
        q16.push_back(d[7:0]);
      end
      if (v && ir24) begin
        q24.push_back(d[23:16]);
        q24.push_back(d[15:8]);
        q24.push_back(d[7:0]);
      end
    end
  endtask
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 24'h0, 1'b1, 1'b0);
  endtask
  initial begin
    b16.in_valid = 1'b0; b24.in_valid = 1'b0;
    b16.in_data = '0; b24.in_data = '0;
    b16.out_ready = 1'b0; b24.out_ready = 1'b0;
    cyc(1'b0, 24'h0, 1'b1, 1'b1);
    cyc(1'b0, 24'h0, 1'b1, 1'b1);
    cyc(1'b0, 24'h0, 1'b1, 1'b0);
    check("rst_byte16", 32'(b16.out_byte), 32'h0);
    check("rst_byte24", 32'(b24.out_byte), 32'h0);
    cyc(1'b1, 24'h001234, 1'b1, 1'b0);
    drain(4);
    cyc(1'b1, 24'h00ABCD, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 24'h0, 1'b0, 1'b0);
    drain(4);
    cyc(1'b1, 24'h008001, 1'b1, 1'b0);
    cyc(1'b1, 24'h007FFF, 1'b1, 1'b0);
    cyc(1'b1, 24'h007FFF, 1'b1, 1'b0);
    drain(4);
    cyc(1'b1, 24'hFFFFFB, 1'b1, 1'b0);
    drain(4);
    cyc(1'b1, 24'h005A5A, 1'b1, 1'b0);
    cyc(1'b0, 24'h0, 1'b1, 1'b0);
    cyc(1'b0, 24'h0, 1'b1, 1'b1);
    cyc(1'b1, 24'h000102, 1'b1, 1'b0);
    drain(4);
    cyc(1'b1, 24'h123456, 1'b1, 1'b0);
    drain(4);
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom), 24'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    drain(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_sample_serializer.md
Name: fir_sample_serializer

Overview:
- Reads signed FIR output samples and unloads each as a stream of bytes to the UART transmitter.
- It is the byte-side counterpart of the parallel-load sample register used elsewhere in the design.
- Sits between the FIR datapath output and the UART TX byte interface.
- Uses valid/ready handshakes on both sides and sends bytes most-significant first.

Parameters:
- width, 16, sample width in bits. Must be a multiple of 8 and at least 8.
- nbytes, width/8, derived localparam giving the number of bytes per sample. It is not overridable.

Ports:
- clock  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  a sample is offered on in
- in_ready  output  1  the block accepts in this cycle
- in  input  width (signed)  sample to serialize
- out_valid  output  1  out_byte holds a byte for the UART TX
- out_ready  input  1  UART TX accepts out_byte this cycle
- out_byte  output  8  current byte
- busy  output  1  a sample is being sent (state SEND)

Behaviour:
- Handshakes:
  - A sample transfers on any edge with in_valid && in_ready.
  - A byte transfers on any edge with out_valid && out_ready.
- State:
  - state: IDLE or SEND.
  - shreg[width-1:0]: holds the sample being sent.
  - cnt: bytes remaining minus 1, range 0..nbytes-1.
- Reset values (also forced whenever reset=1 on an edge, overriding all other activity): state=IDLE, shreg=0, cnt=0, out_valid=0, busy=0, out_byte=0. A sample or byte in flight is discarded; no partial bytes are sent after reset.
- IDLE:
  - in_ready=1, out_valid=0.
  - On sample accept: shreg<=in, cnt<=nbytes-1, go to SEND.
- SEND:
  - out_valid=1; out_byte=shreg[width-1:width-8].
  - On byte accept with cnt>0: shreg<=shreg<<8, cnt<=cnt-1.
  - On byte accept with cnt==0 (last byte):
    - If in_valid, load the new sample (shreg<=in, cnt<=nbytes-1) and stay in SEND. This gives back-to-back streaming with zero bubble cycles.
    - Otherwise go to IDLE.
  - in_ready = (cnt==0) && out_ready. This is the only combinational input-to-output path.
- Latency: a sample accepted at edge k presents its first byte with out_valid=1 in the cycle after edge k.
- Throughput: at full out_ready, one sample per nbytes cycles.
- Backpressure: while out_valid && !out_ready, out_byte, shreg and cnt hold stable.
- Bytes are raw two's-complement slices; no sign processing. Example: -5 at width 16 gives 0xFF then 0xFB.
- in is sampled only on the accept edge; later changes to in have no effect.
- busy = (state==SEND).

Decomposition:
- Shared package/header holds:
  - the state encoding constants (IDLE=0, SEND=1)
  - the BYTE_W=8 constant
  - the default sample width constant, shared with the FIR register and datapath
- One natural sub-module, byte_shift_reg: width-bit register with load and shift-by-8 enables and synchronous reset. The FSM and counter stay in the top module.

Test Plan:
- Single sample: width=16, in=0x1234 with in_valid for 1 cycle, out_ready=1 → out_byte 0x12 then 0x34 on consecutive cycles, first byte 1 cycle after accept. Then out_valid=0 and busy=0.
- Backpressure: in=0xABCD, out_ready held 0 for 5 cycles → out_byte stays 0xAB with out_valid=1 and in_ready=0. After out_ready=1, output is 0xAB then 0xCD.
- Back-to-back: in_valid held with 0x8001 then 0x7FFF, out_ready=1 → stream 0x80,0x01,0x7F,0xFF with no gap. in_ready pulses high only on the cycle 0x01 is accepted.
- Negative sample: in=-5 → bytes 0xFF, 0xFB.
- Reset mid-operation: accept 0x5A5A, assert reset the cycle after the first byte is accepted → next cycle out_valid=0, busy=0, in_ready=1. A new sample 0x0102 then produces exactly 0x01, 0x02.
- Parameter check, width=24: in=0x123456 → 0x12, 0x34, 0x56. in_ready is low until the third byte is accepted.
